// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the multi-cycle MIPS front end: the instruction-fetch
// state encoding, the opcode field position within a 32-bit instruction word
// (also used by decoder_control), and the HALT opcode.
// -----------------------------------------------------------------------------
package mips_pkg;

    // Fetch-unit sequencing states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALT   = 3'd4
    } fetch_state_e;

    // Opcode field slice of an instruction word.
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;

    localparam logic [5:0] OPC_HALT = 6'b111111;

    function automatic logic is_halt_opcode(input logic [5:0] opcode);
        return opcode == OPC_HALT;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_if
// Bundles the two buses the fetch unit sits between:
//   imem_addr / imem_ren / imem_rdata  - instruction-memory read port
//   instr / decoder_en / decoder_done  - decoder_control request handshake
// master: the fetch unit (drives address, read enable, instruction, request).
// slave : the memory + decoder side (drives read data and done).
// -----------------------------------------------------------------------------
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ren;
    logic [31:0]       imem_rdata;
    logic [31:0]       instr;
    logic              decoder_en;
    logic              decoder_done;

    modport master (
        output imem_addr, imem_ren, instr, decoder_en,
        input  imem_rdata, decoder_done
    );

    modport slave (
        input  imem_addr, imem_ren, instr, decoder_en,
        output imem_rdata, decoder_done
    );
endinterface

// File: rtl/next_pc_calc.sv
// -----------------------------------------------------------------------------
// next_pc_calc
// Combinational next-PC selection, all arithmetic modulo 2^ADDR_W:
//   jump                  -> jump_address[ADDR_W-1:0]   (highest priority)
//   branch & branch_taken -> pc + 1 + imm_extended[ADDR_W-1:0]
//   otherwise             -> pc + 1
// Ports: pc, jump, branch, branch_taken, imm_extended (word offset),
//        jump_address (26-bit target field) in; next_pc out.
// ADDR_W must not exceed 31.
// -----------------------------------------------------------------------------
module next_pc_calc #(
    parameter int ADDR_W = 8
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic              jump,
    input  logic              branch,
    input  logic              branch_taken,
    input  logic [31:0]       imm_extended,
    input  logic [25:0]       jump_address,
    output logic [ADDR_W-1:0] next_pc
);
    logic [31:0]       jump_wide;
    logic [ADDR_W-1:0] pc_plus1;
    logic [ADDR_W-1:0] jump_target;
    logic [ADDR_W-1:0] branch_target;
    logic              unused_hi;

    // Zero-extend first so the truncation below is legal for any ADDR_W.
    assign jump_wide     = 32'(jump_address);
    assign jump_target   = jump_wide[ADDR_W-1:0];
    // Truncating to ADDR_W bits makes the wrap at 2^ADDR_W implicit.
    assign pc_plus1      = pc + ADDR_W'(1);
    assign branch_target = pc_plus1 + imm_extended[ADDR_W-1:0];

    // Bits above the PC width cannot affect a modulo-2^ADDR_W result.
    assign unused_hi = ^{jump_wide[31:ADDR_W], imm_extended[31:ADDR_W]};

    always_comb begin
        next_pc = pc_plus1;
        if (jump) begin
            next_pc = jump_target;
        end else if (branch && branch_taken) begin
            next_pc = branch_target;
        end
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Producer side of decoder_control in the multi-cycle MIPS datapath. Reads an
// instruction from BRAM, hands it to the decoder with a decoder_en /
// decoder_done handshake, waits for writeback to retire it, then computes the
// next PC (sequential / branch / jump) and fetches again. A HALT opcode parks
// the unit until reset.
// Ports:
//   clk, rst_n         clock (rising edge), async active-low reset
//   start              pulse in IDLE that begins fetching from pc
//   bus (master)       imem_addr/imem_ren/imem_rdata and instr/decoder_en/
//                      decoder_done
//   retire             writeback completion pulse, acted on only in EXEC
//   Jump, Branch,      control-flow info sampled on retire
//   branch_taken
//   imm_extended       sign-extended branch offset, in words
//   jump_address       jump target field
//   pc                 PC of the instruction in flight
//   busy, halted       status: busy outside IDLE/HALT, halted in HALT
// MEM_LAT (1..4) is the imem read latency in cycles.
// -----------------------------------------------------------------------------
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter int              ADDR_W   = 8,
    parameter int              MEM_LAT  = 1,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    instr_fetch_unit_if.master bus,
    input  logic              retire,
    input  logic              Jump,
    input  logic              Branch,
    input  logic              branch_taken,
    input  logic [31:0]       imm_extended,
    input  logic [25:0]       jump_address,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted
);
    localparam int CNT_W = 3;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic              ren_q, ren_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] next_pc;

    next_pc_calc #(
        .ADDR_W(ADDR_W)
    ) u_next_pc_calc (
        .pc           (pc_q),
        .jump         (Jump),
        .branch       (Branch),
        .branch_taken (branch_taken),
        .imm_extended (imm_extended),
        .jump_address (jump_address),
        .next_pc      (next_pc)
    );

    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ren_d   = 1'b0;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                    ren_d   = 1'b1;
                    cnt_d   = '0;
                end
            end

            // cnt_q is 0 in the imem_ren cycle and reaches MEM_LAT in the
            // cycle where imem_rdata holds the word addressed by pc.
            ST_FETCH: begin
                if (cnt_q == CNT_W'(MEM_LAT)) begin
                    instr_d = bus.imem_rdata;
                    state_d = is_halt_opcode(bus.imem_rdata[OPC_MSB:OPC_LSB])
                              ? ST_HALT : ST_DECODE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_DECODE: begin
                if (bus.decoder_done) begin
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                if (retire) begin
                    pc_d    = next_pc;
                    state_d = ST_FETCH;
                    ren_d   = 1'b1;
                    cnt_d   = '0;
                end
            end

            ST_HALT: state_d = ST_HALT;

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            ren_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ren_q   <= ren_d;
            cnt_q   <= cnt_d;
        end
    end

    // All outputs come straight from flops or decode state_q, so an async
    // reset (including a reset mid-handshake) drops them immediately.
    assign bus.imem_addr  = pc_q;
    assign bus.imem_ren   = ren_q;
    assign bus.instr      = instr_q;
    assign bus.decoder_en = (state_q == ST_DECODE);
    assign pc             = pc_q;
    assign busy           = (state_q != ST_IDLE) && (state_q != ST_HALT);
    assign halted         = (state_q == ST_HALT);
endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
    localparam int LAT  = 1;
    localparam int LAT3 = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, start3;
    logic        retire, Jump, Branch, branch_taken;
    logic [31:0] imm_extended;
    logic [25:0] jump_address;
    logic [7:0]  pc, pc3;
    logic        busy, halted, busy3, halted3;

    int n_compared   = 0;
    int n_mismatched = 0;
    bit cmp_en       = 1'b0;

    always #5 clk = ~clk;

    instr_fetch_unit_if #(.ADDR_W(8)) bus  ();
    instr_fetch_unit_if #(.ADDR_W(8)) bus3 ();

    instr_fetch_unit #(.ADDR_W(8), .MEM_LAT(LAT), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
        .retire(retire), .Jump(Jump), .Branch(Branch), .branch_taken(branch_taken),
        .imm_extended(imm_extended), .jump_address(jump_address),
        .pc(pc), .busy(busy), .halted(halted)
    );

    instr_fetch_unit #(.ADDR_W(8), .MEM_LAT(LAT3), .RESET_PC(8'h00)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .bus(bus3),
        .retire(1'b0), .Jump(1'b0), .Branch(1'b0), .branch_taken(1'b0),
        .imm_extended(32'h0), .jump_address(26'h0),
        .pc(pc3), .busy(busy3), .halted(halted3)
    );

    // Instruction memory: read data appears LAT cycles after imem_ren and is
    // poisoned in every other cycle, so a mistimed capture is visible.
    logic [31:0] mem [256];
    logic [31:0] p1_d [4];
    logic        p1_v [4];
    logic [31:0] p3_d [4];
    logic        p3_v [4];

    always @(posedge clk) begin
        p1_d[0] <= mem[bus.imem_addr];
        p1_v[0] <= bus.imem_ren;
        p3_d[0] <= mem[bus3.imem_addr];
        p3_v[0] <= bus3.imem_ren;
        for (int i = 1; i < 4; i++) begin
            p1_d[i] <= p1_d[i-1];
            p1_v[i] <= p1_v[i-1];
            p3_d[i] <= p3_d[i-1];
            p3_v[i] <= p3_v[i-1];
        end
    end
    assign bus.imem_rdata  = p1_v[LAT-1]  ? p1_d[LAT-1]  : 32'hDEAD_BEEF;
    assign bus3.imem_rdata = p3_v[LAT3-1] ? p3_d[LAT3-1] : 32'hDEAD_BEEF;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a request (start or retire) launches a fetch whose
    // word lands MEM_LAT+1 edges later; the decode request then stays up until
    // done, and the instruction executes until retire picks the next PC.
    logic [7:0]  m_pc;
    logic [31:0] m_instr;
    logic        m_ren, m_den, m_exec, m_halt, m_fetch;
    int          m_wait;

    always @(posedge clk or negedge rst_n) begin : model
        logic [7:0]  n_pc;
        logic [31:0] n_instr;
        logic        n_ren, n_den, n_exec, n_halt, n_fetch;
        int          n_wait;
        int          sum;
        if (!rst_n) begin
            m_pc <= 8'h00; m_instr <= '0; m_ren <= 1'b0; m_den <= 1'b0;
            m_exec <= 1'b0; m_halt <= 1'b0; m_fetch <= 1'b0; m_wait <= 0;
        end else begin
            n_pc = m_pc; n_instr = m_instr; n_ren = 1'b0; n_den = m_den;
            n_exec = m_exec; n_halt = m_halt; n_fetch = m_fetch; n_wait = m_wait;
            if (m_fetch) begin
                n_wait = m_wait - 1;
                if (n_wait == 0) begin
                    n_fetch = 1'b0;
                    n_instr = mem[m_pc];
                    if (n_instr[31:26] == 6'h3F) n_halt = 1'b1;
                    else                         n_den  = 1'b1;
                end
            end else if (m_den) begin
                if (bus.decoder_done) begin
                    n_den  = 1'b0;
                    n_exec = 1'b1;
                end
            end else if (m_exec) begin
                if (retire) begin
                    if (Jump) begin
                        n_pc = jump_address[7:0];
                    end else if (Branch && branch_taken) begin
                        sum  = int'(m_pc) + 1 + int'($signed(imm_extended));
                        n_pc = 8'(sum & 255);
                    end else begin
                        n_pc = 8'((int'(m_pc) + 1) % 256);
                    end
                    n_exec = 1'b0; n_fetch = 1'b1; n_wait = LAT + 1; n_ren = 1'b1;
                end
            end else if (!m_halt && start) begin
                n_fetch = 1'b1; n_wait = LAT + 1; n_ren = 1'b1;
            end
            m_pc <= n_pc; m_instr <= n_instr; m_ren <= n_ren; m_den <= n_den;
            m_exec <= n_exec; m_halt <= n_halt; m_fetch <= n_fetch; m_wait <= n_wait;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("imem_ren",   32'(bus.imem_ren),   32'(m_ren));
            check("imem_addr",  32'(bus.imem_addr),  32'(m_pc));
            check("instr",      bus.instr,           m_instr);
            check("decoder_en", 32'(bus.decoder_en), 32'(m_den));
            check("pc",         32'(pc),             32'(m_pc));
            check("busy",       32'(busy),           32'(m_fetch | m_den | m_exec));
            check("halted",     32'(halted),         32'(m_halt));
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic pulse_done();
        bus.decoder_done = 1'b1;
        @(posedge clk); #1;
        bus.decoder_done = 1'b0;
    endtask

    task automatic retire_op(input logic j, input logic b, input logic t,
                             input logic [31:0] imm, input logic [25:0] ja);
        Jump = j; Branch = b; branch_taken = t; imm_extended = imm; jump_address = ja;
        retire = 1'b1;
        @(posedge clk); #1;
        retire = 1'b0; Jump = 1'b0; Branch = 1'b0; branch_taken = 1'b0;
        imm_extended = '0; jump_address = '0;
    endtask

    // Counts edges from the current point until decoder_en is seen high.
    task automatic wait_den(output int n);
        n = 0;
        while (bus.decoder_en !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (bus.decoder_en !== 1'b1) check("decoder_en_timeout", 32'(bus.decoder_en), 32'h1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pc"},         32'(pc),             32'h00);
        check({tag, "_imem_addr"},  32'(bus.imem_addr),  32'h00);
        check({tag, "_imem_ren"},   32'(bus.imem_ren),   32'h0);
        check({tag, "_instr"},      bus.instr,           32'h0);
        check({tag, "_decoder_en"}, 32'(bus.decoder_en), 32'h0);
        check({tag, "_busy"},       32'(busy),           32'h0);
        check({tag, "_halted"},     32'(halted),         32'h0);
    endtask

    initial begin
        int n;
        bit den_seen;
        rst_n = 1'b0; start = 1'b0; start3 = 1'b0; retire = 1'b0;
        Jump = 1'b0; Branch = 1'b0; branch_taken = 1'b0;
        imm_extended = '0; jump_address = '0;
        bus.decoder_done = 1'b0; bus3.decoder_done = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 | i;
        mem[0] = 32'h8B88_0000;

        repeat (2) @(posedge clk); #1;
        cmp_en = 1'b1;
        check_reset_values("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // First fetch from address 0.
        pulse_start();
        check("start_ren",  32'(bus.imem_ren),  32'h1);
        check("start_addr", 32'(bus.imem_addr), 32'h00);
        wait_den(n);
        check("start_to_den", n, 32'd2);
        check("instr0", bus.instr, 32'h8B88_0000);
        pulse_done();
        check("den_fall",  32'(bus.decoder_en), 32'h0);
        check("busy_exec", 32'(busy), 32'h1);

        // Sequential step from pc=5.
        retire_op(1'b1, 1'b0, 1'b0, 32'h0, 26'h5);
        check("jump5_pc", 32'(pc), 32'h05);
        wait_den(n); pulse_done();
        retire_op(1'b0, 1'b0, 1'b0, 32'h0, 26'h0);
        check("seq_pc",   32'(pc),            32'h06);
        check("seq_addr", 32'(bus.imem_addr), 32'h06);
        check("seq_ren",  32'(bus.imem_ren),  32'h1);
        wait_den(n);
        check("retire_to_den", n, 32'd2);
        check("seq_instr", bus.instr, 32'h1000_0006);
        pulse_done();

        // Branch taken / not taken from pc=10 with offset -4.
        retire_op(1'b1, 1'b0, 1'b0, 32'h0, 26'd10);
        wait_den(n); pulse_done();
        retire_op(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 26'h0);
        check("br_taken_pc", 32'(pc), 32'h07);
        wait_den(n); pulse_done();
        retire_op(1'b1, 1'b0, 1'b0, 32'h0, 26'd10);
        wait_den(n); pulse_done();
        retire_op(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 26'h0);
        check("br_not_taken_pc", 32'(pc), 32'h0B);
        wait_den(n);

        // retire together with decoder_done in DECODE: only done acts.
        bus.decoder_done = 1'b1; retire = 1'b1;
        @(posedge clk); #1;
        bus.decoder_done = 1'b0; retire = 1'b0;
        check("both_pc",  32'(pc),             32'h0B);
        check("both_den", 32'(bus.decoder_en), 32'h0);
        check("both_ren", 32'(bus.imem_ren),   32'h0);
        // decoder_done in EXEC is ignored.
        pulse_done();
        check("done_in_exec_busy", 32'(busy), 32'h1);

        // Jump has priority over a taken branch.
        retire_op(1'b1, 1'b1, 1'b1, 32'h0000_0010, 26'h0000042);
        check("jump_prio_pc", 32'(pc), 32'h42);
        wait_den(n); pulse_done();

        // Wrap 0xFF -> 0x00, where a HALT word now sits.
        retire_op(1'b1, 1'b0, 1'b0, 32'h0, 26'h00000FF);
        check("jump_ff_pc", 32'(pc), 32'hFF);
        wait_den(n);
        mem[0] = 32'hFC00_0000;
        pulse_done();
        retire_op(1'b0, 1'b0, 1'b0, 32'h0, 26'h0);
        check("wrap_pc", 32'(pc), 32'h00);
        den_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            den_seen |= bus.decoder_en;
        end
        check("halt_no_den", 32'(den_seen), 32'h0);
        check("halt_halted", 32'(halted),   32'h1);
        check("halt_busy",   32'(busy),     32'h0);
        check("halt_instr",  bus.instr,     32'hFC00_0000);
        pulse_start();
        check("halt_start_ren", 32'(bus.imem_ren), 32'h0);
        check("halt_sticky",    32'(halted),       32'h1);

        // Reset leaves HALT.
        #2 rst_n = 1'b0;
        #1 check_reset_values("rst_halt");
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem[0] = 32'h8B88_0000;
        @(posedge clk); #1;

        // Reset in the middle of a decode handshake at pc=0x33.
        pulse_start();
        wait_den(n); pulse_done();
        retire_op(1'b1, 1'b0, 1'b0, 32'h0, 26'h33);
        wait_den(n);
        check("pre_rst_den", 32'(bus.decoder_en), 32'h1);
        check("pre_rst_pc",  32'(pc),             32'h33);
        #2 rst_n = 1'b0;
        #1 check_reset_values("rst_decode");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        pulse_start();
        check("restart_ren",  32'(bus.imem_ren),  32'h1);
        check("restart_addr", 32'(bus.imem_addr), 32'h00);
        wait_den(n);
        check("restart_to_den", n, 32'd2);
        check("restart_instr", bus.instr, 32'h8B88_0000);

        // MEM_LAT=3 instance: start to decoder_en is 4 cycles.
        start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        n = 0;
        while (bus3.decoder_en !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("lat3_start_to_den", n, 32'd4);
        check("lat3_instr", bus3.instr, 32'h8B88_0000);
        check("lat3_busy",  32'(busy3), 32'h1);

        @(posedge clk); #1;
        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Producer side of the decoder_control interface: fetches 32-bit instructions from instruction memory and presents them on instr with a decoder_en / decoder_done handshake.
- Waits for retirement of each instruction, then computes the next PC from sequential, branch or jump information.
- Sits between instruction memory (BRAM) and decoder_control in the multi-cycle MIPS datapath.

Parameters:
- ADDR_W, 8, word-address width of PC and instruction memory.
- MEM_LAT, 1, instruction-memory read latency in cycles (legal range 1..4).
- RESET_PC, 0, PC value after reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse that begins fetching from the current PC.
- imem_addr  out  ADDR_W  instruction-memory word address.
- imem_ren  out  1  instruction-memory read enable.
- imem_rdata  in  32  instruction-memory read data, valid MEM_LAT cycles after imem_ren.
- instr  out  32  instruction to decoder_control.
- decoder_en  out  1  decode request.
- decoder_done  in  1  decoder completion pulse.
- retire  in  1  pulse from writeback marking the current instruction complete.
- Jump  in  1  jump indicator from the decoder, sampled on retire.
- Branch  in  1  branch indicator from the decoder, sampled on retire.
- branch_taken  in  1  ALU zero/compare result, sampled on retire.
- imm_extended  in  32  sign-extended branch offset, in words.
- jump_address  in  26  jump target field.
- pc  out  ADDR_W  PC of the instruction currently in flight.
- busy  out  1  high in every state except IDLE and HALT.
- halted  out  1  high in HALT.

Behaviour:
- Reset: async on rst_n low. All outputs below take these values immediately:
  - state = IDLE.
  - pc = RESET_PC.
  - imem_addr = RESET_PC.
  - imem_ren = 0, instr = 0, decoder_en = 0, busy = 0, halted = 0.
- Reset mid-operation aborts any handshake. decoder_en drops without waiting for decoder_done.
- States: IDLE, FETCH, DECODE, EXEC, HALT.
- IDLE: on start go to FETCH. imem_addr = pc, imem_ren = 1 for exactly one cycle.
- FETCH:
  - A latency counter counts MEM_LAT cycles after the imem_ren cycle.
  - On expiry, capture imem_rdata into instr and go to DECODE.
  - imem_ren = 0 during the wait cycles.
- DECODE:
  - decoder_en = 1 from the first DECODE cycle until decoder_done is sampled high.
  - Go to EXEC the cycle after decoder_done. decoder_en is 0 in EXEC.
  - Exception: if instr[31:26] == 6'b111111 (HALT opcode), go straight to HALT without asserting decoder_en.
- EXEC: wait for retire. Compute next PC, all arithmetic modulo 2^ADDR_W:
  - Jump = 1: pc <= jump_address[ADDR_W-1:0]. Jump has priority over Branch.
  - else Branch & branch_taken: pc <= pc + 1 + imm_extended[ADDR_W-1:0].
  - else: pc <= pc + 1.
  - Then issue the next fetch: FETCH, imem_ren = 1, imem_addr = new pc. No return to IDLE.
- HALT: sticky, halted = 1. Left only via reset.
- Stability: instr is stable from capture until the next capture. pc is stable from FETCH entry through EXEC.
- Inputs ignored outside their state:
  - decoder_done outside DECODE.
  - retire outside EXEC.
  - start outside IDLE.
- If retire and decoder_done arrive in the same cycle, only the one matching the current state acts.
- Wrap: pc = 2^ADDR_W-1 followed by a sequential step gives pc = 0.
- Latency: sequential instruction, start to decoder_en = MEM_LAT+1 cycles. retire to next decoder_en = MEM_LAT+1 cycles.

Decomposition:
- Shared package mips_pkg holds:
  - state encoding constants.
  - OPC_HALT = 6'b111111.
  - opcode field slice positions, also used by decoder_control.
- One natural sub-module, next_pc_calc: combinational jump/branch/sequential selection and modulo arithmetic. Kept separate so it can be unit-tested.

Test Plan:
- Reset then start, mem[0]=32'h8B880000, MEM_LAT=1 -> imem_ren pulse at addr 0. instr=32'h8B880000 with decoder_en high 2 cycles after start. decoder_en falls the cycle after decoder_done.
- Sequential run: retire with Jump=0, Branch=0 at pc=5 -> pc=6, imem_addr=6, next decoder_en 2 cycles later.
- Branch taken: pc=10, Branch=1, branch_taken=1, imm_extended=32'hFFFFFFFC -> pc=7. Same case with branch_taken=0 -> pc=11.
- Jump priority: Jump=1, Branch=1, branch_taken=1, jump_address=26'h0000042 -> pc=8'h42.
- Wrap and halt: pc=8'hFF sequential step -> pc=0. mem[0]=32'hFC000000 -> halted=1, decoder_en never asserted, start ignored.
- Reset mid-DECODE, with decoder_en high and no decoder_done -> outputs take reset values immediately. A later start fetches from RESET_PC. MEM_LAT=3 variant gives start-to-decoder_en = 4 cycles.
